sseg_scan_controller: RTL and testbench

//  Time-multiplexes NDIG hex digits onto one shared common-anode 7-segment decoder and segment bus.

---
 rtl/sseg_scan_controller_pkg.sv | 13 +
 rtl/sseg_scan_controller_if.sv | 25 ++
 rtl/sseg_scan_controller_slot_timer.sv | 50 +++++
 rtl/sseg_scan_controller.sv | 157 +++++++++++++++
 tb/tb_sseg_scan_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sseg_scan_controller_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding and
// default slot timing for the 50 MHz board clock.
package sseg_scan_controller_pkg;

   localparam int DWELL_DEF = 50000;
   localparam int BLANK_DEF = 500;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

endpackage

// File: rtl/sseg_scan_controller_if.sv
// Load and display bus between the value sources, the scan controller and
// the downstream hex decoder / anode pins.
interface sseg_scan_controller_if #(
   parameter int NDIG = 4
);
   logic              en;
   logic              load;
   logic [4*NDIG-1:0] value;
   logic [NDIG-1:0]   dp_mask;
   logic              lz_en;
   logic [3:0]        hex;
   logic              dp;
   logic [NDIG-1:0]   anode;
   logic              frame_done;

   modport master (
      output en, load, value, dp_mask, lz_en,
      input  hex, dp, anode, frame_done
   );

   modport slave (
      input  en, load, value, dp_mask, lz_en,
      output hex, dp, anode, frame_done
   );
endinterface

// File: rtl/sseg_scan_controller_slot_timer.sv
// Slot timer: cycle counter within a digit slot and the digit index, with
// blank-end, slot-end and frame-end terminal-count flags.
module sseg_scan_controller_slot_timer #(
   parameter int NDIG  = 4,
   parameter int DWELL = 50000,
   parameter int BLANK = 500
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic                    en,
   output logic [$clog2(NDIG)-1:0] idx,
   output logic                    blank_end,
   output logic                    slot_end,
   output logic                    frame_end
);
   localparam int CW = $clog2(DWELL);
   localparam int IW = $clog2(NDIG);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;

   assign blank_end = (cnt_q == CW'(BLANK - 1));
   assign slot_end  = (cnt_q == CW'(DWELL - 1));
   assign frame_end = slot_end && (idx_q == IW'(NDIG - 1));
   assign idx       = idx_q;

   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (slot_end) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end
endmodule

// File: rtl/sseg_scan_controller.sv
// Multiplexes NDIG hex digits onto a shared common-anode decoder with
// double-buffered loads, per-slot anti-ghost blanking and leading-zero blanking.
//
//   state   | meaning
//   S_BLANK | all anodes off; hex/dp for the current slot settle
//   S_DRIVE | anode of the current digit low (unless blanked)
module sseg_scan_controller
   import sseg_scan_controller_pkg::*;
#(
   parameter int NDIG  = 4,
   parameter int DWELL = DWELL_DEF,
   parameter int BLANK = BLANK_DEF
) (
   input logic                   clk,
   input logic                   nrst,
   sseg_scan_controller_if.slave bus
);
   localparam int              IW        = $clog2(NDIG);
   localparam logic [NDIG-1:0] ANODE_OFF = '1;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx;
   logic              blank_end, slot_end, frame_end, frame_done;

   logic [4*NDIG-1:0] sh_value_q, sh_value_d, act_value_q, act_value_d;
   logic [NDIG-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic              sh_lz_q, sh_lz_d, act_lz_q, act_lz_d;
   logic              sh_vld_q, sh_vld_d, act_vld_q, act_vld_d;

   logic [NDIG-1:0]   anode_q, anode_d;
   logic [3:0]        hex_q, hex_d;
   logic              dp_q, dp_d;

   logic [NDIG-1:0]   lz_blank;
   logic              zero_run;
   logic              slot_off;

   sseg_scan_controller_slot_timer #(
      .NDIG  (NDIG),
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) u_timer (
      .clk       (clk),
      .nrst      (nrst),
      .en        (bus.en),
      .idx       (idx),
      .blank_end (blank_end),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   assign frame_done     = frame_end & bus.en;
   assign bus.frame_done = frame_done;
   assign bus.anode      = anode_q;
   assign bus.hex        = hex_q;
   assign bus.dp         = dp_q;

   // A load landing in the frame_done cycle reaches the shadow only; the
   // active copy takes the pre-edge shadow, so it shows one frame later.
   always_comb begin
      sh_value_d  = sh_value_q;
      sh_dp_d     = sh_dp_q;
      sh_lz_d     = sh_lz_q;
      sh_vld_d    = sh_vld_q;
      act_value_d = act_value_q;
      act_dp_d    = act_dp_q;
      act_lz_d    = act_lz_q;
      act_vld_d   = act_vld_q;
      if (bus.load) begin
         sh_value_d = bus.value;
         sh_dp_d    = bus.dp_mask;
         sh_lz_d    = bus.lz_en;
         sh_vld_d   = 1'b1;
      end
      if (frame_done) begin
         act_value_d = sh_value_q;
         act_dp_d    = sh_dp_q;
         act_lz_d    = sh_lz_q;
         act_vld_d   = sh_vld_q;
      end
   end

   always_comb begin
      lz_blank = '0;
      zero_run = 1'b1;
      for (int k = NDIG - 1; k >= 0; k--) begin
         zero_run    = zero_run && (act_value_q[4*k +: 4] == 4'h0);
         lz_blank[k] = act_lz_q && (k != 0) && zero_run && !act_dp_q[k];
      end
   end

   // Nothing is shown until a loaded value has become active.
   assign slot_off = !act_vld_q || lz_blank[idx];

   always_comb begin
      state_d = state_q;
      anode_d = anode_q;
      hex_d   = hex_q;
      dp_d    = dp_q;
      if (!bus.en) begin
         state_d = S_BLANK;
         anode_d = ANODE_OFF;
      end else begin
         case (state_q)
            S_BLANK: begin
               anode_d = ANODE_OFF;
               hex_d   = act_value_q[4*idx +: 4];
               dp_d    = act_dp_q[idx] & ~slot_off;
               if (blank_end) begin
                  state_d      = S_DRIVE;
                  anode_d[idx] = slot_off;
               end
            end
            S_DRIVE: begin
               if (slot_end) begin
                  state_d = S_BLANK;
                  anode_d = ANODE_OFF;
               end
            end
            default: begin
               state_d = S_BLANK;
               anode_d = ANODE_OFF;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_BLANK;
         anode_q     <= ANODE_OFF;
         hex_q       <= '0;
         dp_q        <= 1'b0;
         sh_value_q  <= '0;
         sh_dp_q     <= '0;
         sh_lz_q     <= 1'b0;
         sh_vld_q    <= 1'b0;
         act_value_q <= '0;
         act_dp_q    <= '0;
         act_lz_q    <= 1'b0;
         act_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         anode_q     <= anode_d;
         hex_q       <= hex_d;
         dp_q        <= dp_d;
         sh_value_q  <= sh_value_d;
         sh_dp_q     <= sh_dp_d;
         sh_lz_q     <= sh_lz_d;
         sh_vld_q    <= sh_vld_d;
         act_value_q <= act_value_d;
         act_dp_q    <= act_dp_d;
         act_lz_q    <= act_lz_d;
         act_vld_q   <= act_vld_d;
      end
   end
endmodule

// File: tb/tb_sseg_scan_controller.sv
// Bench for sseg_scan_controller: a frame-position model drives a scoreboard
// of expected per-slot displays, popped at the first drive cycle of each slot.
module tb_sseg_scan_controller;
   localparam int NDIG  = 4;
   localparam int DWELL = 10;
   localparam int BLANK = 2;
   localparam int FRAME = NDIG * DWELL;

   typedef struct {
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       hex_chk;
   } slot_t;

   logic clk;
   logic nrst;
   int   n_chk  = 0;
   int   n_pass = 0;

   sseg_scan_controller_if #(.NDIG(NDIG)) bus ();

   sseg_scan_controller #(
      .NDIG  (NDIG),
      .DWELL (DWELL),
      .BLANK (BLANK)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   slot_t       sb_q[$];
   int          ph;
   logic [15:0] sh_val, act_val;
   logic [3:0]  sh_dp, act_dp;
   logic        sh_lz, act_lz, sh_v, act_v;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // Reference model: frame position plus shadow/active copies.
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ph      <= 0;
         sh_val  <= '0; sh_dp  <= '0; sh_lz  <= 1'b0; sh_v  <= 1'b0;
         act_val <= '0; act_dp <= '0; act_lz <= 1'b0; act_v <= 1'b0;
      end else begin
         if (!bus.en) ph <= 0;
         else         ph <= (ph == FRAME - 1) ? 0 : ph + 1;
         if (bus.en && ph == FRAME - 1) begin
            act_val <= sh_val; act_dp <= sh_dp; act_lz <= sh_lz; act_v <= sh_v;
         end
         if (bus.load) begin
            sh_val <= bus.value; sh_dp <= bus.dp_mask; sh_lz <= bus.lz_en; sh_v <= 1'b1;
         end
      end
   end

   function automatic slot_t slot_exp(input int k);
      slot_t s;
      logic  off;
      off = !act_v || (act_lz && k != 0 && !act_dp[k] && ((act_val >> (4*k)) == 16'h0));
      s.an = 4'hF;
      if (!off) s.an[k] = 1'b0;
      s.hex     = act_val[4*k +: 4];
      s.dp      = act_dp[k] && !off;
      s.hex_chk = !off;
      return s;
   endfunction

   task automatic push_frame();
      for (int k = 0; k < NDIG; k++) sb_q.push_back(slot_exp(k));
   endtask

   always @(negedge clk) begin
      slot_t e;
      check_eq("onehot_anode", 32'($countones(~bus.anode) <= 1), 1);
      check_eq("frame_done", bus.frame_done, (ph == FRAME - 1) && bus.en);
      if ((ph % DWELL) < BLANK) check_eq("blank_interval", bus.anode, 4'hF);
      if ((ph % DWELL) == BLANK && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("slot_anode", bus.anode, e.an);
         check_eq("slot_dp", bus.dp, e.dp);
         if (e.hex_chk) check_eq("slot_hex", bus.hex, e.hex);
      end
   end

   task automatic wait_ph(input int p);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (ph != p && n < 4 * FRAME);
      check_eq("wait_ph_timeout", ph == p, 1);
   endtask

   task automatic wait_frame_end();
      wait_ph(FRAME - 1);
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic lz);
      bus.load = 1'b1; bus.value = v; bus.dp_mask = m; bus.lz_en = lz;
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask

   initial begin
      nrst = 1'b0;
      bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0; bus.lz_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_anode", bus.anode, 4'hF);
      check_eq("reset_hex", bus.hex, 4'h0);
      check_eq("reset_dp", bus.dp, 1'b0);
      check_eq("reset_frame_done", bus.frame_done, 1'b0);
      nrst = 1'b1;
      bus.en = 1'b1;

      // Basic scan of 12AF.
      do_load(16'h12AF, 4'b0000, 1'b0);
      wait_frame_end();
      push_frame();

      // Leading-zero blanking, then a dp that protects digit 2.
      do_load(16'h0050, 4'b0000, 1'b1);
      wait_frame_end();
      push_frame();
      do_load(16'h0050, 4'b0100, 1'b1);
      wait_frame_end();
      push_frame();

      // Two loads in one frame: the current frame is untouched, last one wins.
      wait_ph(13);
      do_load(16'h1111, 4'b0000, 1'b0);
      wait_ph(25);
      do_load(16'h2222, 4'b0000, 1'b0);
      wait_frame_end();
      push_frame();
      wait_frame_end();

      // en dropped mid-slot, load while disabled, restart at digit 0.
      wait_ph(16);
      bus.en = 1'b0;
      @(posedge clk); #1;
      check_eq("en_off_anode", bus.anode, 4'hF);
      do_load(16'h8765, 4'b0000, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("en_off_hold", bus.anode, 4'hF);
      bus.en = 1'b1;
      push_frame();
      wait_frame_end();
      push_frame();
      wait_frame_end();

      // Load coinciding with the frame_done cycle lands one frame later.
      do_load(16'hBEEF, 4'b0001, 1'b0);
      wait_ph(FRAME - 1);
      do_load(16'h3C3C, 4'b0000, 1'b0);
      push_frame();
      wait_frame_end();
      push_frame();
      wait_frame_end();

      // Asynchronous reset during a drive slot.
      wait_ph(15);
      #3 nrst = 1'b0;
      #1;
      check_eq("async_rst_anode", bus.anode, 4'hF);
      check_eq("async_rst_hex", bus.hex, 4'h0);
      check_eq("async_rst_dp", bus.dp, 1'b0);
      sb_q.delete();
      @(posedge clk); #1;
      nrst = 1'b1;
      push_frame();
      wait_frame_end();
      push_frame();
      do_load(16'h4321, 4'b1000, 1'b0);
      wait_frame_end();
      push_frame();
      wait_frame_end();

      check_eq("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
